// File: rtl/dot_matrix_scanner_if.sv
// Signal bundle between the pattern-load logic, the matrix drivers and the scanner.
// The master side supplies mode/frame selection and frame-buffer writes; the slave
// side (the scanner) returns the registered row/column drive and the scan pulse.
interface dot_matrix_scanner_if #(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int FRAMES = 4
);
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [1:0]      mode;
  logic [FW-1:0]   sel_frame;
  logic            wr_en;
  logic [FW-1:0]   wr_frame;
  logic [RW-1:0]   wr_row;
  logic [COLS-1:0] wr_data;
  logic [RW-1:0]   row_bin;
  logic [ROWS-1:0] row_onehot;
  logic [COLS-1:0] col;
  logic            frame_tick;

  modport master (
    output mode, sel_frame, wr_en, wr_frame, wr_row, wr_data,
    input  row_bin, row_onehot, col, frame_tick
  );

  modport slave (
    input  mode, sel_frame, wr_en, wr_frame, wr_row, wr_data,
    output row_bin, row_onehot, col, frame_tick
  );
endinterface

// File: rtl/dot_matrix_scanner.sv
// Row-scanning LED matrix driver with an internal multi-frame bitmap buffer.
// Display settings (mode, selected frame, animation frame, scroll offset) only
// change at the end of a full scan, and the first row of the new scan is built
// from the new settings, so a frame is never shown half in one setting and half
// in another. Row select and column data are registered on the same edge.
module dot_matrix_scanner #(
  parameter int ROWS       = 16,
  parameter int COLS       = 16,
  parameter int FRAMES     = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int FRAME_HOLD = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dot_matrix_scanner_if.slave   bus
);

  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  localparam logic [1:0] MODE_STATIC  = 2'b00;
  localparam logic [1:0] MODE_ANIMATE = 2'b01;
  localparam logic [1:0] MODE_SCROLL  = 2'b10;
  localparam logic [1:0] MODE_BLANK   = 2'b11;

  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(FRAME_HOLD - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

  // Rotate a row bitmap left: result[(i+off) mod COLS] = data[i].
  function automatic logic [COLS-1:0] rotate_left(input logic [COLS-1:0] data,
                                                  input logic [CW-1:0]   off);
    logic [2*COLS-1:0] dbl;
    dbl = {data, data} << off;
    return dbl[2*COLS-1:COLS];
  endfunction

  // Scan datapath state
  logic [DW-1:0]   div_cnt_q,    div_cnt_d;
  logic [RW-1:0]   row_bin_q,    row_bin_d;
  logic [ROWS-1:0] row_onehot_q, row_onehot_d;
  logic [COLS-1:0] col_q,        col_d;
  logic            frame_tick_q, frame_tick_d;

  // Display-setting state, updated only at end of scan
  logic [1:0]      mode_q,       mode_d;
  logic [FW-1:0]   sel_q,        sel_d;
  logic [HW-1:0]   hold_cnt_q,   hold_cnt_d;
  logic [FW-1:0]   cur_frame_q,  cur_frame_d;
  logic [CW-1:0]   scroll_off_q, scroll_off_d;

  logic [COLS-1:0] fb_q [FRAMES][ROWS];

  logic            row_tick_s;
  logic            scan_end_s;
  logic            step_s;
  logic [RW-1:0]   next_row_s;
  logic [FW-1:0]   sel_in_s;
  logic [FW-1:0]   disp_frame_s;
  logic [COLS-1:0] row_word_s;
  logic            wr_ok_s;

  assign row_tick_s = (div_cnt_q == DIV_LAST);
  assign scan_end_s = row_tick_s && (row_bin_q == ROW_LAST);
  assign next_row_s = (row_bin_q == ROW_LAST) ? {RW{1'b0}} : (row_bin_q + RW'(1));
  assign sel_in_s   = (int'(bus.sel_frame) < FRAMES) ? bus.sel_frame : {FW{1'b0}};
  assign wr_ok_s    = bus.wr_en && (int'(bus.wr_frame) < FRAMES) && (int'(bus.wr_row) < ROWS);

  // End-of-scan update of mode, frame selection, hold counter, animation and scroll
  always_comb begin
    mode_d       = mode_q;
    sel_d        = sel_q;
    hold_cnt_d   = hold_cnt_q;
    cur_frame_d  = cur_frame_q;
    scroll_off_d = scroll_off_q;
    step_s       = 1'b0;
    if (scan_end_s) begin
      mode_d = bus.mode;
      sel_d  = sel_in_s;
      if (bus.mode != mode_q) begin
        hold_cnt_d = {HW{1'b0}};
      end else if (hold_cnt_q == HOLD_LAST) begin
        hold_cnt_d = {HW{1'b0}};
        step_s     = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end
      if (step_s && (bus.mode == MODE_ANIMATE)) begin
        cur_frame_d = (cur_frame_q == FRAME_LAST) ? {FW{1'b0}} : (cur_frame_q + FW'(1));
      end else begin
        cur_frame_d = cur_frame_q;
      end
      if (bus.mode != MODE_SCROLL) begin
        scroll_off_d = {CW{1'b0}};
      end else if (step_s) begin
        scroll_off_d = (scroll_off_q == COL_LAST) ? {CW{1'b0}} : (scroll_off_q + CW'(1));
      end else begin
        scroll_off_d = scroll_off_q;
      end
    end else begin
      step_s = 1'b0;
    end
  end

  // Column data for the row about to be driven, built from the settings in force for it
  always_comb begin
    disp_frame_s = (mode_d == MODE_ANIMATE) ? cur_frame_d : sel_d;
    row_word_s   = fb_q[disp_frame_s][next_row_s];
    case (mode_d)
      MODE_STATIC:  col_d = row_word_s;
      MODE_ANIMATE: col_d = row_word_s;
      MODE_SCROLL:  col_d = rotate_left(row_word_s, scroll_off_d);
      MODE_BLANK:   col_d = {COLS{1'b0}};
      default:      col_d = {COLS{1'b0}};
    endcase
  end

  // Row divider and next row select / end-of-scan pulse
  always_comb begin
    frame_tick_d = scan_end_s;
    if (row_tick_s) begin
      div_cnt_d    = {DW{1'b0}};
      row_bin_d    = next_row_s;
      row_onehot_d = {{(ROWS-1){1'b0}}, 1'b1} << next_row_s;
    end else begin
      div_cnt_d    = div_cnt_q + DW'(1);
      row_bin_d    = row_bin_q;
      row_onehot_d = row_onehot_q;
    end
  end

  // Scan registers: row select and column data change together on row_tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= {DW{1'b0}};
      row_bin_q    <= {RW{1'b0}};
      row_onehot_q <= {{(ROWS-1){1'b0}}, 1'b1};
      col_q        <= {COLS{1'b0}};
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      row_bin_q    <= row_bin_d;
      row_onehot_q <= row_onehot_d;
      col_q        <= row_tick_s ? col_d : col_q;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Display-setting registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= MODE_STATIC;
      sel_q        <= {FW{1'b0}};
      hold_cnt_q   <= {HW{1'b0}};
      cur_frame_q  <= {FW{1'b0}};
      scroll_off_q <= {CW{1'b0}};
    end else begin
      mode_q       <= mode_d;
      sel_q        <= sel_d;
      hold_cnt_q   <= hold_cnt_d;
      cur_frame_q  <= cur_frame_d;
      scroll_off_q <= scroll_off_d;
    end
  end

  // Frame buffer: one write per clock; a same-edge display read sees the old word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < FRAMES; f++) begin
        for (int r = 0; r < ROWS; r++) begin
          fb_q[f][r] <= {COLS{1'b0}};
        end
      end
    end else if (wr_ok_s) begin
      fb_q[bus.wr_frame][bus.wr_row] <= bus.wr_data;
    end
  end

  assign bus.row_bin    = row_bin_q;
  assign bus.row_onehot = row_onehot_q;
  assign bus.col        = col_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Scoreboard bench for dot_matrix_scanner: a scan-level reference model pushes the
// expected row/column/frame_tick for every row advance; a monitor pops and compares
// whenever the DUT changes row, and checks that outputs hold steady in between.
module tb_dot_matrix_scanner;
  localparam int ROWS = 16, COLS = 16, FRAMES = 4, SCAN_DIV = 4, FRAME_HOLD = 2;
  localparam int SCAN = ROWS * SCAN_DIV;
  localparam int RW = $clog2(ROWS);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dot_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS), .FRAMES(FRAMES)) bus ();

  dot_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .FRAMES(FRAMES),
    .SCAN_DIV(SCAN_DIV), .FRAME_HOLD(FRAME_HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int              row;
    logic [COLS-1:0] col;
    logic            ft;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: time in clock edges since reset, settings per scan
  logic [COLS-1:0] mem [FRAMES][ROWS];
  int k;
  int m_mode, m_sel, base, scans;

  task automatic model_step();
    int cur_row, new_row, frame, off;
    logic [COLS-1:0] data;
    exp_t e;
    if (!rst_n) begin
      k = 0; m_mode = 0; m_sel = 0; base = 0; scans = 0;
      exp_q.delete();
      for (int f = 0; f < FRAMES; f++)
        for (int r = 0; r < ROWS; r++) mem[f][r] = '0;
    end else begin
      if (k % SCAN_DIV == SCAN_DIV - 1) begin
        cur_row = (k / SCAN_DIV) % ROWS;
        new_row = (cur_row + 1) % ROWS;
        if (cur_row == ROWS - 1) begin
          if (int'(bus.mode) != m_mode) begin
            if (m_mode == 1) base = (base + scans / FRAME_HOLD) % FRAMES;
            m_mode = int'(bus.mode);
            scans = 0;
          end else begin
            scans++;
          end
          m_sel = (int'(bus.sel_frame) < FRAMES) ? int'(bus.sel_frame) : 0;
        end
        frame = (m_mode == 1) ? (base + scans / FRAME_HOLD) % FRAMES : m_sel;
        off   = (m_mode == 2) ? (scans / FRAME_HOLD) % COLS : 0;
        data  = mem[frame][new_row];
        e.col = '0;
        if (m_mode != 3)
          for (int i = 0; i < COLS; i++) e.col[(i + off) % COLS] = data[i];
        e.row = new_row;
        e.ft  = (cur_row == ROWS - 1);
        exp_q.push_back(e);
      end
      if (bus.wr_en && int'(bus.wr_frame) < FRAMES && int'(bus.wr_row) < ROWS)
        mem[bus.wr_frame][bus.wr_row] = bus.wr_data;
      k++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // Monitor: compare on every row change, check stability otherwise
  initial begin
    int prev_row;
    logic [COLS-1:0] last_col;
    logic [ROWS-1:0] exp_oh;
    logic [RW-1:0]   exp_row;
    exp_t e;
    prev_row = 0;
    last_col = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_row = 0;
        last_col = '0;
      end else if (int'(bus.row_bin) != prev_row) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_row_change: row_bin=%0d with no expected advance at %0t", bus.row_bin, $time);
        end else begin
          e = exp_q.pop_front();
          exp_row = e.row[RW-1:0];
          exp_oh = '0;
          exp_oh[e.row] = 1'b1;
          checks++;
          if (bus.row_bin !== exp_row) begin
            errors++;
            $display("FAIL row_bin: got %0d expected %0d at %0t", bus.row_bin, exp_row, $time);
          end
          checks++;
          if (bus.row_onehot !== exp_oh) begin
            errors++;
            $display("FAIL row_onehot: got %h expected %h at %0t", bus.row_onehot, exp_oh, $time);
          end
          checks++;
          if (bus.col !== e.col) begin
            errors++;
            $display("FAIL col_row%0d: got %h expected %h at %0t", e.row, bus.col, e.col, $time);
          end
          checks++;
          if (bus.frame_tick !== e.ft) begin
            errors++;
            $display("FAIL frame_tick_edge: got %b expected %b at %0t", bus.frame_tick, e.ft, $time);
          end
          last_col = e.col;
        end
        prev_row = int'(bus.row_bin);
      end else begin
        checks++;
        if (bus.frame_tick !== 1'b0) begin
          errors++;
          $display("FAIL frame_tick_idle: got %b expected 0 at %0t", bus.frame_tick, $time);
        end
        checks++;
        if (bus.col !== last_col) begin
          errors++;
          $display("FAIL col_hold: got %h expected %h at %0t", bus.col, last_col, $time);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bus.row_bin !== '0 || bus.row_onehot !== 16'h0001 || bus.col !== 16'h0000 || bus.frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL %s: got row_bin=%0d onehot=%h col=%h ft=%b expected 0/0001/0000/0",
               tag, bus.row_bin, bus.row_onehot, bus.col, bus.frame_tick);
    end
  endtask

  task automatic run_scans(input int n);
    repeat (n * SCAN) @(negedge clk);
  endtask

  task automatic write_word(input int f, input int r, input logic [COLS-1:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_frame = f[1:0]; bus.wr_row = r[RW-1:0]; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Wait (at a falling edge) until the next rising edge has scan-relative index ph
  task automatic wait_phase(input int ph);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4 * SCAN && !found; i++) begin
      @(negedge clk);
      if (k % SCAN == ph) found = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL wait_phase_timeout: phase %0d not reached", ph);
    end
  endtask

  initial begin
    bus.mode = 2'b00; bus.sel_frame = '0; bus.wr_en = 1'b0;
    bus.wr_frame = '0; bus.wr_row = '0; bus.wr_data = '0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset_state");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Blank buffer, static mode
    run_scans(2);

    // Static frame 2 row 5, then reset while row 5 is lit
    write_word(2, 5, 16'hA5A5);
    bus.sel_frame = 2'd2;
    run_scans(2);
    wait_phase(21);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset_midscan");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Animate through four frames
    write_word(0, 0, 16'h0001);
    write_word(1, 0, 16'h0002);
    write_word(2, 0, 16'h0004);
    write_word(3, 0, 16'h0008);
    bus.mode = 2'b01;
    run_scans(10);

    // Scroll-left of frame 1 row 3, then back to static
    write_word(1, 3, 16'h8001);
    bus.sel_frame = 2'd1;
    bus.mode = 2'b10;
    run_scans(36);
    bus.mode = 2'b00;
    run_scans(3);

    // Blank with mode change issued mid-scan
    wait_phase(30);
    bus.mode = 2'b11;
    run_scans(2);
    wait_phase(40);
    bus.mode = 2'b00;
    bus.sel_frame = 2'd0;
    run_scans(2);

    // Same-edge write/read of row 7, and a write to an undisplayed frame
    write_word(0, 7, 16'h1234);
    run_scans(1);
    wait_phase(27);
    bus.wr_en = 1'b1; bus.wr_frame = 2'd0; bus.wr_row = 4'd7; bus.wr_data = 16'hBEEF;
    @(negedge clk);
    bus.wr_en = 1'b0;
    write_word(3, 7, 16'hFFFF);
    run_scans(2);

    // Randomised writes and mode/frame changes
    for (int i = 0; i < 40 * SCAN; i++) begin
      @(negedge clk);
      bus.wr_en = ($urandom_range(3) == 0);
      bus.wr_frame = 2'($urandom_range(FRAMES - 1));
      bus.wr_row = 4'($urandom_range(ROWS - 1));
      bus.wr_data = 16'($urandom);
      if ($urandom_range(149) == 0) begin
        bus.mode = 2'($urandom_range(3));
        bus.sel_frame = 2'($urandom_range(FRAMES - 1));
      end
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    run_scans(1);

    @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_rows: got %0d unconsumed expected row advances, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_matrix_scanner.md
Name: dot_matrix_scanner

Overview:
- Parametrised successor to the combinational 16x16 row-to-column pattern table.
- Holds FRAMES writable bitmap frames in an internal frame buffer.
- Row-scans the LED matrix with a programmable row dwell.
- Supports four display modes: static, animate, scroll-left and blank.
- Sits between the pattern-load logic and the matrix row/column drivers. Its registered row/column outputs drive the board pins directly.

Parameters:
- ROWS, 16, number of matrix rows.
- COLS, 16, number of matrix columns (width of col).
- FRAMES, 4, number of stored frames.
- SCAN_DIV, 1000, clocks each row is held (≥1).
- FRAME_HOLD, 50, full scans per animate/scroll step (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  00 static, 01 animate, 10 scroll-left, 11 blank.
- sel_frame  in  clog2(FRAMES)  frame shown in static/scroll modes.
- wr_en  in  1  frame-buffer write strobe.
- wr_frame  in  clog2(FRAMES)  write frame index.
- wr_row  in  clog2(ROWS)  write row index.
- wr_data  in  COLS  row bitmap to write (bit i = column i lit).
- row_bin  out  clog2(ROWS)  row currently driven.
- row_onehot  out  ROWS  one-hot active-high row enable, bit row_bin set.
- col  out  COLS  active-high column data for row_bin.
- frame_tick  out  1  one-cycle pulse on completion of each full scan.

Behaviour:
- Reset (async, rst_n=0): the following all go to 0.
  - div_cnt, row_bin, hold_cnt, cur_frame, scroll_off, col, frame_tick.
  - Every frame-buffer word.
  - row_onehot = 1 (row 0 enabled).
  - active mode register = 00.
- Reset deasserted mid-scan: scanning restarts from row 0, div_cnt 0.
- Row tick:
  - div_cnt counts 0..SCAN_DIV-1.
  - row_tick is asserted when div_cnt == SCAN_DIV-1; div_cnt then wraps to 0.
- Row advance on row_tick:
  - row_bin increments and wraps ROWS-1 -> 0.
  - row_onehot, row_bin and col update on the same edge. No cycle exists where row and column data disagree.
- Column data: col = f(frame buffer[display_frame][next row], mode, scroll_off), registered. This gives one-edge latency from the row_tick cycle, aligned with the row_bin change.
- End of scan:
  - The row_tick at row_bin == ROWS-1 asserts frame_tick for exactly one cycle, coincident with row_bin becoming 0.
  - hold_cnt counts frame_ticks 0..FRAME_HOLD-1.
  - The wrap of hold_cnt generates step_tick (internal).
- Mode application:
  - The mode input is sampled into the active mode register only on frame_tick. A whole frame is never torn.
  - hold_cnt clears when the sampled mode differs from the previous one.
  - scroll_off clears when leaving scroll-left.
- Static (00): display_frame = sel_frame, sampled on frame_tick.
- Animate (01): cur_frame increments on step_tick and wraps FRAMES-1 -> 0; display_frame = cur_frame.
- Scroll-left (10):
  - display_frame = sel_frame.
  - scroll_off increments on step_tick and wraps COLS-1 -> 0.
  - col = stored row rotated left by scroll_off, i.e. col[(i+off) mod COLS] = data[i].
- Blank (11): col forced to 0. Counters, row_onehot and frame_tick keep running.
- Out-of-range indices:
  - sel_frame ≥ FRAMES is treated as 0.
  - A write with wr_frame ≥ FRAMES or wr_row ≥ ROWS is ignored.
- Writes:
  - wr_en stores wr_data into buffer[wr_frame][wr_row] on the rising edge.
  - A write and a display read of the same word on the same edge: the display gets the old data; the new data appears on the next scan of that row.
  - Writes are accepted in every mode and at any time; no handshake, one write per clock.
- Degenerate parameters: SCAN_DIV=1 advances the row every clock. FRAMES=1 makes animate identical to static.

Test Plan:
(Bench parameters: ROWS=16, COLS=16, FRAMES=4, SCAN_DIV=4, FRAME_HOLD=2.)
- Reset, no writes, mode 00 -> row_bin steps 0..15, one step every 4 clocks. row_onehot tracks row_bin. col=0 throughout. frame_tick pulses once per 64 clocks.
- Write frame 2 row 5 = 16'hA5A5, sel_frame=2, mode 00 -> col=16'hA5A5 exactly while row_bin==5, 0 on other rows. Assert rst_n low mid-scan -> all outputs 0 and row_onehot=1 immediately, without waiting for a clock.
- Frames 0..3 row 0 = 16'h0001, 0002, 0004, 0008; mode 01 -> row-0 col sequence 0001, 0002, 0004, 0008, 0001, each value held for 2 scans (128 clocks).
- Frame 1 row 3 = 16'h8001, sel_frame=1, mode 10 -> row-3 col sequence 8001, 0003, 0006, 000C; offset wraps after 16 steps back to 8001. Switching to mode 00 restores 8001 at the next frame_tick.
- Mode 11 after loading data -> col=0 on all rows; row_bin and frame_tick unaffected. A mode change mid-scan takes effect only at the next frame_tick.
- Write to row 7 on the same edge that row 7 is loaded for display -> old value shown this scan, new value shown next scan. A write with wr_row=7 and wr_frame=3 in mode 00 with sel_frame=0 leaves the display unchanged.
